// File: rtl/uart_sram_host.sv
// Host-side initiator for the UART SRAM command protocol: serializes one read/write request
// into command/data bytes and collects the reply into a single response pulse.
module uart_sram_host #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TO_W           = 17,
    parameter logic [7:0]  ACK_BYTE       = 8'hAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        rsp_error,
    output logic        busy,
    output logic        tx_enable,
    output logic        tx_valid,
    output logic [7:0]  tx_data_in,
    input  logic        tx_ready,
    output logic        rx_enable,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data_out
);

    typedef enum logic [2:0] {StIdle, StSendCmd, StSendData, StWaitRsp, StDone} state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [4:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      idx_q, idx_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [23:0]     shadow_q, shadow_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            timeout_q, timeout_d;
    logic            error_q, error_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            to_cnt_q  <= '0;
            shadow_q  <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            to_cnt_q  <= to_cnt_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        to_cnt_d   = to_cnt_q;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;
        timeout_d  = timeout_q;
        error_d    = error_q;
        req_ready  = 1'b0;
        tx_valid   = 1'b0;
        tx_data_in = 8'h00;
        rsp_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d      = req_we;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    timeout_d = 1'b0;
                    error_d   = 1'b0;
                    state_d   = StSendCmd;
                end
            end
            StSendCmd: begin
                tx_valid   = 1'b1;
                tx_data_in = {we_q, 2'b00, addr_q};
                if (tx_ready) begin
                    idx_d    = 2'd0;
                    to_cnt_d = '0;
                    state_d  = we_q ? StSendData : StWaitRsp;
                end
            end
            StSendData: begin
                tx_valid = 1'b1;
                unique case (idx_q)
                    2'd0: tx_data_in = wdata_q[7:0];
                    2'd1: tx_data_in = wdata_q[15:8];
                    2'd2: tx_data_in = wdata_q[23:16];
                    2'd3: tx_data_in = wdata_q[31:24];
                    default: tx_data_in = 8'h00;
                endcase
                if (tx_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        to_cnt_d = '0;
                        state_d  = StWaitRsp;
                    end
                end
            end
            StWaitRsp: begin
                // An arriving byte takes priority over the timeout threshold.
                if (rx_valid) begin
                    to_cnt_d = '0;
                    if (we_q) begin
                        error_d = (rx_data_out != ACK_BYTE);
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        unique case (idx_q)
                            2'd0: shadow_d[7:0]   = rx_data_out;
                            2'd1: shadow_d[15:8]  = rx_data_out;
                            2'd2: shadow_d[23:16] = rx_data_out;
                            2'd3: begin
                                rdata_d = {rx_data_out, shadow_q};
                                state_d = StDone;
                            end
                            default: ;
                        endcase
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StDone: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = rsp_valid & timeout_q;
    assign rsp_error   = rsp_valid & error_q;
    assign busy        = (state_q != StIdle);
    assign tx_enable   = 1'b1;
    assign rx_enable   = 1'b1;

endmodule

// File: tb/tb_uart_sram_host.sv
// Scoreboard bench for uart_sram_host: TX bytes and responses are queued when requests are
// issued and compared by a monitor when the DUT produces them.
module tb_uart_sram_host;

    typedef struct {
        logic [31:0] rdata;
        logic        to;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_timeout, rsp_error, busy;
    logic [31:0] rsp_rdata;
    logic        tx_enable, tx_valid, tx_ready, rx_enable, rx_valid;
    logic [7:0]  tx_data_in, rx_data_out;

    int          checks = 0;
    int          errors = 0;
    int          tx_mode = 0;  // 0: ready always, 1: random, 2: held low
    logic [31:0] model_rdata = 32'h0;
    logic [7:0]  exp_tx[$];
    rsp_t        exp_rsp[$];

    uart_sram_host #(
        .TIMEOUT_CYCLES(50),
        .TO_W          (6),
        .ACK_BYTE      (8'hAA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .rsp_error  (rsp_error),
        .busy       (busy),
        .tx_enable  (tx_enable),
        .tx_valid   (tx_valid),
        .tx_data_in (tx_data_in),
        .tx_ready   (tx_ready),
        .rx_enable  (rx_enable),
        .rx_valid   (rx_valid),
        .rx_data_out(rx_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                1:       tx_ready = 1'($urandom_range(0, 1));
                2:       tx_ready = 1'b0;
                default: tx_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor: TX handshakes, TX stability under backpressure, responses.
    initial begin
        logic       stall;
        logic [7:0] stall_data;
        logic [7:0] eb;
        rsp_t       er;
        stall = 1'b0;
        stall_data = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    checks++;
                    if (tx_valid !== 1'b1 || tx_data_in !== stall_data) begin
                        errors++;
                        $display("FAIL tx_stable: valid=%0b data=%02h, required valid=1 data=%02h",
                                 tx_valid, tx_data_in, stall_data);
                    end
                end
                if (tx_valid && tx_ready) begin
                    checks++;
                    if (exp_tx.size() == 0) begin
                        errors++;
                        $display("FAIL tx_unexpected: byte=%02h, required no byte", tx_data_in);
                    end else begin
                        eb = exp_tx.pop_front();
                        if (tx_data_in !== eb) begin
                            errors++;
                            $display("FAIL tx_byte: got %02h, required %02h", tx_data_in, eb);
                        end
                    end
                end
                if (rsp_valid) begin
                    checks++;
                    if (exp_rsp.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: rdata=%08h, required no response",
                                 rsp_rdata);
                    end else begin
                        er = exp_rsp.pop_front();
                        if (rsp_rdata !== er.rdata || rsp_timeout !== er.to
                            || rsp_error !== er.err) begin
                            errors++;
                            $display("FAIL rsp: rdata=%08h to=%0b err=%0b, required %08h %0b %0b",
                                     rsp_rdata, rsp_timeout, rsp_error, er.rdata, er.to, er.err);
                        end
                    end
                end
                stall = tx_valid && !tx_ready;
                stall_data = tx_data_in;
            end
        end
    end

    // Issue one request; called and returns at posedge+1.
    task automatic do_req(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
        int n;
        exp_tx.push_back({we, 2'b00, addr});
        if (we) begin
            exp_tx.push_back(wdata[7:0]);
            exp_tx.push_back(wdata[15:8]);
            exp_tx.push_back(wdata[23:16]);
            exp_tx.push_back(wdata[31:24]);
        end
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL req_accept: req_ready=%0b after %0d cycles, required 1", req_ready, n);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data_out = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int left);
        int n = 0;
        while (exp_tx.size() > left && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_tx.size() > left) begin
            errors++;
            $display("FAIL tx_wait: %0d bytes pending, required %0d", exp_tx.size(), left);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (exp_rsp.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL rsp_wait: %0d responses pending, required 0", exp_rsp.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, tx_enable, rx_enable, busy, tx_valid, rsp_valid, rsp_timeout, rsp_error}
            !== 8'b1110_0000 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%08b rdata=%08h, required 11100000 00000000",
                     {req_ready, tx_enable, rx_enable, busy, tx_valid, rsp_valid, rsp_timeout,
                      rsp_error}, rsp_rdata);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        int hs = 0;
        int gap = 0;
        exp_rsp.push_back('{rdata: model_rdata, to: 1'b0, err: 1'b0});
        do_req(1'b1, 5'd5, 32'hDEADBEEF);
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy: req_ready=%0b busy=%0b, required 0 1", req_ready, busy);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) hs++;
            else if (hs > 0 && hs < 5) gap++;
        end
        checks++;
        if (hs != 5 || gap != 0) begin
            errors++;
            $display("FAIL write_burst: handshakes=%0d gaps=%0d, required 5 0", hs, gap);
        end
        @(posedge clk);
        #1;
        send_rx(8'hAA);
        wait_rsp();
    endtask

    task automatic test_read(input logic [4:0] addr, input logic [31:0] data);
        logic [31:0] prev = model_rdata;
        model_rdata = data;
        exp_rsp.push_back('{rdata: data, to: 1'b0, err: 1'b0});
        do_req(1'b0, addr, 32'h0);
        wait_tx(0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 10)) begin
                @(posedge clk);
                #1;
            end
            send_rx(data[8*i +: 8]);
            if (i == 2) begin
                checks++;
                if (rsp_rdata !== prev) begin
                    errors++;
                    $display("FAIL read_midway: rdata=%08h, required %08h", rsp_rdata, prev);
                end
            end
        end
        wait_rsp();
    endtask

    task automatic test_timeout();
        int n = 0;
        exp_rsp.push_back('{rdata: model_rdata, to: 1'b1, err: 1'b0});
        do_req(1'b0, 5'd7, 32'h0);
        wait_tx(0);
        send_rx(8'hAB);
        send_rx(8'hCD);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp_valid && n < 200);
        checks++;
        if (n != 50 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_latency: rsp_valid=%0b after %0d cycles, required 1 after 50",
                     rsp_valid, n);
        end
        wait_rsp();
    endtask

    task automatic test_write_err();
        exp_rsp.push_back('{rdata: model_rdata, to: 1'b0, err: 1'b1});
        tx_mode = 1;
        do_req(1'b1, 5'h1A, $urandom);
        wait_tx(0);
        tx_mode = 0;
        send_rx(8'h55);
        wait_rsp();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_req(1'b1, 5'd2, 32'h11223344);
        wait_tx(2);
        tx_mode = 2;
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b1 || tx_data_in !== 8'h22) begin
            errors++;
            $display("FAIL mid_index2: valid=%0b data=%02h, required 1 22", tx_valid, tx_data_in);
        end
        #2;
        reset = 1'b1;
        exp_tx.delete();
        #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%0b tx_valid=%0b req_ready=%0b rsp_valid=%0b, required 0 0 1 0",
                     busy, tx_valid, req_ready, rsp_valid);
        end
        model_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tx_mode = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_quiet: %0d active cycles after reset, required 0", seen);
        end
        test_read(5'd4, 32'h04030201);
    endtask

    task automatic test_stray();
        send_rx(8'hFF);
        send_rx(8'h00);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_rx(8'h13);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: busy=%0b, required 0", busy);
        end
        test_read(5'h1F, 32'hF0DEBC9A);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rx_valid = 1'b0;
        rx_data_out = 8'h00;
        test_reset();
        test_write();
        test_read(5'd3, 32'h12345678);
        test_timeout();
        test_write_err();
        test_reset_mid();
        test_stray();
        checks++;
        if (exp_tx.size() != 0) begin
            errors++;
            $display("FAIL tx_leftover: %0d bytes never sent, required 0", exp_tx.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
